// File: rtl/shr_operand_fifo.sv
// ---------------------------------------------------------------------------
// shr_operand_fifo
//
// Operand staging buffer in front of the SHR logical-shift-right datapath.
// Producer pushes {a, sh_amt} pairs over a valid/ready handshake; the oldest
// pair is presented first-word-fall-through on a / sh_amt, which wire
// directly to the SHR instance. The consumer that samples SHR's d result
// acknowledges the head entry with out_ready.
//
// Parameters
//   DATAWIDTH : width of a, sh_amt and each stored field (match the SHR fed)
//   DEPTH     : number of entries, power of two, >= 2
//
// Ports
//   Clk        in   rising-edge clock
//   Rst        in   asynchronous reset, active-low (clears all state)
//   in_valid   in   producer offers a pair on in_a / in_sh_amt
//   in_ready   out  FIFO can accept a pair (count != DEPTH)
//   in_a       in   operand to be shifted
//   in_sh_amt  in   shift amount
//   out_valid  out  head entry valid on a / sh_amt (count != 0)
//   out_ready  in   consumer takes the head entry this cycle
//   a          out  head operand, to SHR.a
//   sh_amt     out  head shift amount, to SHR.sh_amt
//   count      out  current occupancy, 0..DEPTH
//
// Optional feature (macro SHR_FIFO_ERR_EN)
//   When defined, adds sticky error outputs:
//   err_ovf    out  set when in_valid is seen while the FIFO is full
//   err_udf    out  set when out_ready is seen while the FIFO is empty
//   Both clear only on reset and never influence data or pointers.
// ---------------------------------------------------------------------------
module shr_operand_fifo #(
  parameter int DATAWIDTH = 2,
  parameter int DEPTH     = 4
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATAWIDTH-1:0]   in_a,
  input  logic [DATAWIDTH-1:0]   in_sh_amt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATAWIDTH-1:0]   a,
  output logic [DATAWIDTH-1:0]   sh_amt,
  output logic [$clog2(DEPTH):0] count
`ifdef SHR_FIFO_ERR_EN
  ,
  output logic                   err_ovf,
  output logic                   err_udf
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * DATAWIDTH;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  // Read view of the storage, one element per entry register.
  logic [EW-1:0] mem_q [DEPTH];

  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  // -------------------------------------------------------------------------
  // Handshake decode: both flags come from the registered count only, so
  // in_ready has no combinational dependence on out_ready. A full FIFO
  // refuses a push even in a cycle where it also pops.
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = (count_q != FULL_CNT);
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // -------------------------------------------------------------------------
  // Pointer and occupancy next-state. DEPTH is a power of two, so the
  // natural AW-bit rollover gives the DEPTH-1 -> 0 wrap.
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // -------------------------------------------------------------------------
  // Storage: one register per entry. Every entry is cleared by reset so a
  // freshly reset FIFO shows a = sh_amt = 0 rather than leftover data.
  // Fields are stored untouched; shift semantics belong to SHR.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic          we;
      logic [EW-1:0] entry_q;
      logic [EW-1:0] entry_d;

      assign we = push && (wr_ptr_q == AW'(gi));

      always_comb begin
        entry_d = entry_q;
        if (we) begin
          entry_d = {in_a, in_sh_amt};
        end
      end

      always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
          entry_q <= '0;
        end else begin
          entry_q <= entry_d;
        end
      end

      assign mem_q[gi] = entry_q;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // First-word-fall-through head. The read is purely combinational from
  // registered storage and rd_ptr, so the head is stable whenever no pop
  // happens. When empty it shows the stale entry under rd_ptr; consumers
  // qualify with out_valid.
  // -------------------------------------------------------------------------
  assign head   = mem_q[rd_ptr_q];
  assign a      = head[EW-1:DATAWIDTH];
  assign sh_amt = head[DATAWIDTH-1:0];
  assign count  = count_q;

  // -------------------------------------------------------------------------
  // Sticky protocol-error flags. They observe the raw requests against the
  // registered count and feed nothing back into the datapath.
  // -------------------------------------------------------------------------
`ifdef SHR_FIFO_ERR_EN
  logic err_ovf_q, err_ovf_d;
  logic err_udf_q, err_udf_d;

  always_comb begin
    err_ovf_d = err_ovf_q;
    err_udf_d = err_udf_q;
    if (in_valid && (count_q == FULL_CNT)) begin
      err_ovf_d = 1'b1;
    end
    if (out_ready && (count_q == '0)) begin
      err_udf_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`else
  // Without the error flags, pushes into a full FIFO and pops from an empty
  // FIFO are simply dropped by the handshake decode above.
`endif

endmodule
